// File: rtl/pr_ready_table.sv
// Physical-register ready table: rename marks PRs busy, execution wakeup tags mark them ready.
// Optional WAKEUP_BYPASS_EN: read ports also see same-cycle nonzero wakeup tags.
module pr_ready_table #(
  parameter int PR_NUM = 64,
  parameter int PR_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc0_vld,
  input  logic            alloc1_vld,
  input  logic [PR_W-1:0] alloc0_PR,
  input  logic [PR_W-1:0] alloc1_PR,
  input  logic [PR_W-1:0] ALU0_dest,
  input  logic [PR_W-1:0] ALU1_dest,
  input  logic [PR_W-1:0] AGU_dest,
  input  logic [PR_W-1:0] BRU_dest,
  input  logic [PR_W-1:0] rd0_PR,
  input  logic [PR_W-1:0] rd1_PR,
  input  logic [PR_W-1:0] rd2_PR,
  input  logic [PR_W-1:0] rd3_PR,
  output logic            rd0_rdy,
  output logic            rd1_rdy,
  output logic            rd2_rdy,
  output logic            rd3_rdy,
  output logic [PR_W:0]   busy_cnt
);

  logic [PR_NUM-1:0] ready;
  logic [PR_NUM-1:0] ready_nxt;
  logic [PR_W:0]     busy_nxt;
  logic [PR_W-1:0]   wake_tag [4];
  logic [PR_W-1:0]   rd_tag   [4];
  logic [3:0]        rd_rdy;

  assign wake_tag = '{ALU0_dest, ALU1_dest, AGU_dest, BRU_dest};
  assign rd_tag   = '{rd0_PR, rd1_PR, rd2_PR, rd3_PR};

  // Allocation beats a same-cycle wakeup: the new producer owns the PR.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ready_nxt = ready;
    busy_nxt  = '0;
    for (int i = 1; i < PR_NUM; i++) begin
      logic alloc_hit;
      logic wake_hit;
      alloc_hit = (alloc0_vld && alloc0_PR == PR_W'(i)) ||
                  (alloc1_vld && alloc1_PR == PR_W'(i));
      wake_hit  = 1'b0;
      for (int w = 0; w < 4; w++)
        if (wake_tag[w] != '0 && wake_tag[w] == PR_W'(i)) wake_hit = 1'b1;
      if (flush)          ready_nxt[i] = 1'b1;
      else if (alloc_hit) ready_nxt[i] = 1'b0;
      else if (wake_hit)  ready_nxt[i] = 1'b1;
    end
    ready_nxt[0] = 1'b1;
    for (int i = 0; i < PR_NUM; i++)
      busy_nxt = busy_nxt + (PR_W+1)'(~ready_nxt[i]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the table is a flop vector, not RAM, so a full synchronous reset is intended.
    if (!rst_n) begin
      ready    <= '1;
      busy_cnt <= '0;
    end else begin
      ready    <= ready_nxt;
      busy_cnt <= busy_nxt;
    end
  end

  always_comb begin
    rd_rdy = '0;
    for (int n = 0; n < 4; n++) begin
      rd_rdy[n] = ready[rd_tag[n]];
`ifdef WAKEUP_BYPASS_EN
      for (int w = 0; w < 4; w++)
        if (wake_tag[w] != '0 && wake_tag[w] == rd_tag[n]) rd_rdy[n] = 1'b1;
`endif
    end
  end

  assign rd0_rdy = rd_rdy[0];
  assign rd1_rdy = rd_rdy[1];
  assign rd2_rdy = rd_rdy[2];
  assign rd3_rdy = rd_rdy[3];

endmodule

// File: tb/tb_pr_ready_table.sv
// Self-checking bench for pr_ready_table: directed vector table plus multi-cycle sequences.
module tb_pr_ready_table;

`ifdef WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, flush, alloc0_vld, alloc1_vld;
  logic [5:0] alloc0_PR, alloc1_PR, ALU0_dest, ALU1_dest, AGU_dest, BRU_dest;
  logic [5:0] rd0_PR, rd1_PR, rd2_PR, rd3_PR;
  logic       rd0_rdy, rd1_rdy, rd2_rdy, rd3_rdy;
  logic [6:0] busy_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pr_ready_table dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc0_vld(alloc0_vld), .alloc1_vld(alloc1_vld),
    .alloc0_PR(alloc0_PR), .alloc1_PR(alloc1_PR),
    .ALU0_dest(ALU0_dest), .ALU1_dest(ALU1_dest), .AGU_dest(AGU_dest), .BRU_dest(BRU_dest),
    .rd0_PR(rd0_PR), .rd1_PR(rd1_PR), .rd2_PR(rd2_PR), .rd3_PR(rd3_PR),
    .rd0_rdy(rd0_rdy), .rd1_rdy(rd1_rdy), .rd2_rdy(rd2_rdy), .rd3_rdy(rd3_rdy),
    .busy_cnt(busy_cnt)
  );

  typedef struct {
    logic       flush;
    logic       a0v;
    logic [5:0] a0;
    logic       a1v;
    logic [5:0] a1;
    logic [5:0] alu0, alu1, agu, bru;
    logic [5:0] r0, r1, r2, r3;
    logic [3:0] rdy;   // {rd3,rd2,rd1,rd0}, sampled before this vector's edge
    logic [6:0] cnt;   // busy_cnt sampled before this vector's edge
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; alloc0_vld = 0; alloc1_vld = 0; alloc0_PR = 0; alloc1_PR = 0;
    ALU0_dest = 0; ALU1_dest = 0; AGU_dest = 0; BRU_dest = 0;
    rd0_PR = 0; rd1_PR = 0; rd2_PR = 0; rd3_PR = 0;
  endtask

  function automatic vec_t mk(input logic f, input logic a0v, input int a0, input logic a1v,
                              input int a1, input int alu0, input int alu1, input int agu,
                              input int bru, input int r0, input int r1, input int r2,
                              input int r3, input logic [3:0] rdy, input int cnt);
    vec_t v;
    v.flush = f; v.a0v = a0v; v.a0 = 6'(a0); v.a1v = a1v; v.a1 = 6'(a1);
    v.alu0 = 6'(alu0); v.alu1 = 6'(alu1); v.agu = 6'(agu); v.bru = 6'(bru);
    v.r0 = 6'(r0); v.r1 = 6'(r1); v.r2 = 6'(r2); v.r3 = 6'(r3);
    v.rdy = rdy; v.cnt = 7'(cnt);
    return v;
  endfunction

  // Checks all 64 PRs ready through the four read ports, with idle wakeup buses.
  task automatic check_all_ready(input string name);
    int bad;
    bad = 0;
    idle_inputs();
    for (int p = 0; p < 64; p += 4) begin
      rd0_PR = 6'(p); rd1_PR = 6'(p + 1); rd2_PR = 6'(p + 2); rd3_PR = 6'(p + 3);
      #0.1;
      if ({rd3_rdy, rd2_rdy, rd1_rdy, rd0_rdy} !== 4'b1111) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    // flush a0v a0 a1v a1 | alu0 alu1 agu bru | r0 r1 r2 r3 | rdy{3..0} cnt
    vecs[0]  = mk(0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  1, 63, 12, 4'b1111, 0);
    vecs[1]  = mk(0, 1, 12, 1, 40, 0,  0,  0,  0,  12, 40, 0, 0,  4'b1111, 0);
    vecs[2]  = mk(0, 0, 0,  0, 0,  0,  0,  0,  0,  12, 40, 0, 13, 4'b1100, 2);
    vecs[3]  = mk(0, 0, 0,  0, 0,  0,  12, 0,  0,  12, 40, 0, 0,  {3'b110, BYP}, 2);
    vecs[4]  = mk(0, 1, 20, 0, 0,  0,  0,  0,  0,  12, 40, 0, 0,  4'b1101, 1);
    vecs[5]  = mk(0, 1, 33, 1, 5,  0,  0,  0,  0,  20, 40, 0, 0,  4'b1100, 2);
    vecs[6]  = mk(0, 1, 20, 0, 0,  0,  0,  0,  20, 21, 33, 5, 0,  4'b1001, 4);
    vecs[7]  = mk(0, 0, 0,  0, 0,  5,  0,  33, 5,  20, 12, 33, 0, {1'b1, BYP, 2'b10}, 4);
    vecs[8]  = mk(0, 1, 50, 1, 50, 0,  0,  0,  0,  20, 5, 33, 40, 4'b0110, 2);
    vecs[9]  = mk(0, 1, 0,  1, 0,  0,  0,  0,  0,  50, 20, 0, 0,  4'b1100, 3);
    vecs[10] = mk(0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  50, 40, 20, 4'b0001, 3);

    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("reset_busy_cnt", busy_cnt, 0);
    check_all_ready("reset_all_ready");

    foreach (vecs[k]) begin
      @(negedge clk);
      flush = vecs[k].flush;
      alloc0_vld = vecs[k].a0v; alloc0_PR = vecs[k].a0;
      alloc1_vld = vecs[k].a1v; alloc1_PR = vecs[k].a1;
      ALU0_dest = vecs[k].alu0; ALU1_dest = vecs[k].alu1;
      AGU_dest = vecs[k].agu; BRU_dest = vecs[k].bru;
      rd0_PR = vecs[k].r0; rd1_PR = vecs[k].r1; rd2_PR = vecs[k].r2; rd3_PR = vecs[k].r3;
      #1;
      check($sformatf("vec%0d_rdy", k), {rd3_rdy, rd2_rdy, rd1_rdy, rd0_rdy}, vecs[k].rdy);
      check($sformatf("vec%0d_busy_cnt", k), busy_cnt, vecs[k].cnt);
    end

    // Fill the table: allocate PRs 1..63, one per cycle.
    for (int p = 1; p < 64; p++) begin
      @(negedge clk);
      idle_inputs();
      alloc0_vld = 1; alloc0_PR = 6'(p);
    end
    @(negedge clk);
    idle_inputs();
    rd0_PR = 1; rd1_PR = 7; rd2_PR = 63; rd3_PR = 0;
    #1;
    check("full_busy_cnt", busy_cnt, 63);
    check("full_rdy", {rd3_rdy, rd2_rdy, rd1_rdy, rd0_rdy}, 4'b1000);

    // Flush with a same-cycle allocation: allocation discarded.
    flush = 1; alloc0_vld = 1; alloc0_PR = 7;
    @(negedge clk);
    idle_inputs();
    #1;
    check("flush_busy_cnt", busy_cnt, 0);
    check_all_ready("flush_all_ready");

    // Build some state, then reset together with an allocation: reset dominates.
    @(negedge clk);
    alloc0_vld = 1; alloc0_PR = 9; alloc1_vld = 1; alloc1_PR = 10;
    @(negedge clk);
    idle_inputs();
    rd0_PR = 9; rd1_PR = 10;
    #1;
    check("pre_reset_busy_cnt", busy_cnt, 2);
    check("pre_reset_rdy", {rd1_rdy, rd0_rdy}, 2'b00);
    rst_n = 0; alloc0_vld = 1; alloc0_PR = 11;
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    #1;
    check("mid_reset_busy_cnt", busy_cnt, 0);
    check_all_ready("mid_reset_all_ready");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
